bcd_display_counter: RTL and testbench

BCD_DISPLAY_COUNTER -- requirements
Module: bcd_display_counter

---
 rtl/bcd_display_counter.sv | 210 +++++++++++++++++++++
 tb/tb_bcd_display_counter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_counter.sv
// bcd_display_counter
// Multi-digit BCD up/down counter with a multiplexed 7-segment driver.
// A prescaler sets the count rate. A free-running scan counter steps
// through the digits, driving one active-low anode and its segment pattern.
// The count value, wrap pulse, anode and segment outputs are all registered.

module bcd_display_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   value,
  output logic                  wrap
);

  // Counter widths. A width of 1 is the minimum so that degenerate
  // parameter values (SCAN_DIV=1, DIGITS=1) still elaborate cleanly.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  // Segment patterns {a,b,c,d,e,f,g}, active-low. Non-BCD codes blank the
  // digit. The counter itself never holds a non-BCD code.
  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] pattern;
    pattern = 7'b1111111;
    case (digit)
      4'd0: pattern = 7'b0000001;
      4'd1: pattern = 7'b1001111;
      4'd2: pattern = 7'b0010010;
      4'd3: pattern = 7'b0000110;
      4'd4: pattern = 7'b1001100;
      4'd5: pattern = 7'b0100100;
      4'd6: pattern = 7'b0100000;
      4'd7: pattern = 7'b0001111;
      4'd8: pattern = 7'b0000000;
      4'd9: pattern = 7'b0000100;
      default: pattern = 7'b1111111;
    endcase
    return pattern;
  endfunction

  // State registers
  logic [PW-1:0]          r_presc;
  logic [SW-1:0]          r_scan;
  logic [IW-1:0]          r_idx;
  logic [4*DIGITS-1:0]    r_value;
  logic                   r_wrap;
  logic [DIGITS-1:0]      r_an;
  logic [6:0]             r_seg;

  // Combinational next-state and helper signals
  logic                   w_tick;
  logic [PW-1:0]          w_presc_next;
  logic                   w_scan_last;
  logic [SW-1:0]          w_scan_next;
  logic [IW-1:0]          w_idx_next;
  logic [4*DIGITS-1:0]    w_load_bcd;
  logic [4*DIGITS-1:0]    w_step_value;
  logic                   w_step_wrap;
  logic [4*DIGITS-1:0]    w_value_next;
  logic                   w_wrap_next;
  logic [3:0]             w_next_digit [DIGITS];
  logic [3:0]             w_sel_digit;
  logic [DIGITS-1:0]      w_an_next;
  logic [6:0]             w_seg_next;

  // A count step happens on the last cycle of each prescaler period.
  assign w_tick = en && (r_presc == PRESC_LAST);

  // Prescaler next state: a load restarts the period; en=0 holds it.
  always_comb begin
    w_presc_next = r_presc;
    if (load) begin
      w_presc_next = '0;
    end else if (en) begin
      if (w_tick) begin
        w_presc_next = '0;
      end else begin
        w_presc_next = r_presc + PW'(1);
      end
    end
  end

  // Load value sanitised digit by digit: anything above 9 saturates to 9.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_load_clamp
      assign w_load_bcd[4*gi +: 4] = (load_val[4*gi +: 4] > 4'd9) ? 4'd9
                                                                   : load_val[4*gi +: 4];
    end
  endgenerate

  // Ripple a +1 or -1 through the digits. The carry (or borrow) that
  // leaves the top digit means the whole counter wrapped around.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    w_step_value = r_value;
    carry        = 1'b1;
    digit        = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = r_value[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (digit >= 4'd9) begin
            w_step_value[4*i +: 4] = 4'd0;
          end else begin
            w_step_value[4*i +: 4] = digit + 4'd1;
            carry                  = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            w_step_value[4*i +: 4] = 4'd9;
          end else begin
            w_step_value[4*i +: 4] = digit - 4'd1;
            carry                  = 1'b0;
          end
        end
      end
    end
    w_step_wrap = carry;
  end

  // Value next state: load beats a coincident tick and never signals wrap.
  always_comb begin
    w_value_next = r_value;
    w_wrap_next  = 1'b0;
    if (load) begin
      w_value_next = w_load_bcd;
    end else if (w_tick) begin
      w_value_next = w_step_value;
      w_wrap_next  = w_step_wrap;
    end
  end

  // Scan counter and digit index next state; runs regardless of en.
  assign w_scan_last = (r_scan == SCAN_LAST);

  always_comb begin
    w_scan_next = r_scan + SW'(1);
    w_idx_next  = r_idx;
    if (w_scan_last) begin
      w_scan_next = '0;
      if (r_idx == IDX_LAST) begin
        w_idx_next = '0;
      end else begin
        w_idx_next = r_idx + IW'(1);
      end
    end
  end

  // Display outputs are derived from the next value and next index so that
  // after every edge the lit digit shows exactly what value holds.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_display
      assign w_next_digit[gi] = w_value_next[4*gi +: 4];
      assign w_an_next[gi]    = (w_idx_next != IW'(gi));
    end
  endgenerate

  assign w_sel_digit = w_next_digit[w_idx_next];
  assign w_seg_next  = seg_code(w_sel_digit);

  // Count path registers: prescaler, value and wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_value <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_presc <= w_presc_next;
      r_value <= w_value_next;
      r_wrap  <= w_wrap_next;
    end
  end

  // Scan path registers: slot counter, digit index, anode and segments.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_an   <= {DIGITS{1'b1}} & ~{{(DIGITS-1){1'b0}}, 1'b1};
      r_seg  <= 7'b0000001;
    end else begin
      r_scan <= w_scan_next;
      r_idx  <= w_idx_next;
      r_an   <= w_an_next;
      r_seg  <= w_seg_next;
    end
  end

  assign value = r_value;
  assign wrap  = r_wrap;
  assign an    = r_an;
  assign seg   = r_seg;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Testbench for bcd_display_counter (DIGITS=2, TICK_DIV=4, SCAN_DIV=2).
// The reference model stores the count as a plain integer. It converts
// that integer to BCD and segment codes only when it builds an expected
// observation.

module tb_bcd_display_counter;

  localparam int D    = 2;
  localparam int TD   = 4;
  localparam int SD   = 2;
  localparam int MAXV = 99;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           up;
  logic           load;
  logic [4*D-1:0] load_val;
  logic [6:0]     seg;
  logic [D-1:0]   an;
  logic [4*D-1:0] value;
  logic           wrap;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int   m_cnt   = 0;
  int   m_presc = 0;
  int   m_scan  = 0;
  int   m_idx   = 0;
  logic m_wrap  = 1'b0;

  bcd_display_counter #(
    .DIGITS   (D),
    .TICK_DIV (TD),
    .SCAN_DIV (SD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .seg      (seg),
    .an       (an),
    .value    (value),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [4*D-1:0] to_bcd(input int n);
    logic [4*D-1:0] r;
    int             k;
    r = '0;
    k = n;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(k % 10);
      k = k / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [4*D-1:0] v);
    int n;
    int mult;
    int d;
    n    = 0;
    mult = 1;
    for (int i = 0; i < D; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      n    = n + d * mult;
      mult = mult * 10;
    end
    return n;
  endfunction

  // Expected {value, wrap, an, seg} from the model
  function automatic logic [4*D+D+7:0] exp_obs();
    logic [4*D-1:0] v;
    logic [D-1:0]   a;
    logic [3:0]     dg;
    v        = to_bcd(m_cnt);
    a        = '1;
    a[m_idx] = 1'b0;
    dg       = v[4*m_idx +: 4];
    return {v, m_wrap, a, SEG_TAB[dg]};
  endfunction

  // Advance one clock; model applies the same inputs the DUT sees at the edge
  task automatic clk_step();
    logic tick;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_presc = 0; m_scan = 0; m_idx = 0; m_wrap = 1'b0;
    end else begin
      tick   = en && (m_presc == TD - 1);
      m_wrap = 1'b0;
      if (load) begin
        m_cnt   = from_load(load_val);
        m_presc = 0;
      end else begin
        if (tick) begin
          if (up) begin
            if (m_cnt == MAXV) begin m_cnt = 0; m_wrap = 1'b1; end
            else m_cnt = m_cnt + 1;
          end else begin
            if (m_cnt == 0) begin m_cnt = MAXV; m_wrap = 1'b1; end
            else m_cnt = m_cnt - 1;
          end
        end
        if (en) m_presc = tick ? 0 : m_presc + 1;
      end
      if (m_scan == SD - 1) begin
        m_scan = 0;
        m_idx  = (m_idx + 1) % D;
      end else begin
        m_scan = m_scan + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic [4*D+D+7:0] e;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    for (int c = 0; c < 3; c++) begin
      clk_step();
      e = exp_obs();
      total++;
      if ({value, wrap, an, seg} !== e) begin
        bad++;
        $display("FAIL reset_model cyc=%0d got v=%h w=%b an=%b seg=%b want v=%h w=%b an=%b seg=%b",
                 c, value, wrap, an, seg, e[17:10], e[9], e[8:7], e[6:0]);
      end
    end
    total++;
    if ({value, wrap, an, seg} !== {8'h00, 1'b0, 2'b10, 7'b0000001}) begin
      bad++;
      $display("FAIL reset_const got v=%h w=%b an=%b seg=%b want v=00 w=0 an=10 seg=0000001",
               value, wrap, an, seg);
    end
    $display("test_reset: value=%h an=%b seg=%b", value, an, seg);
  endtask

  task automatic test_count_up();
    logic [4*D+D+7:0] e;
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int c = 0; c < 40; c++) begin
      clk_step();
      e = exp_obs();
      total++;
      if ({value, wrap, an, seg} !== e) begin
        bad++;
        $display("FAIL count_up cyc=%0d got v=%h w=%b an=%b seg=%b want v=%h w=%b an=%b seg=%b",
                 c, value, wrap, an, seg, e[17:10], e[9], e[8:7], e[6:0]);
      end
    end
    total++;
    if (value !== 8'h10) begin
      bad++;
      $display("FAIL count_up_final got=%h want=10", value);
    end
    $display("test_count_up: value=%h after 40 cycles", value);
  endtask

  task automatic test_up_wrap();
    logic [4*D+D+7:0] e;
    int wraps;
    wraps = 0;
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'h99;
    clk_step();
    load = 1'b0;
    for (int c = 0; c < 8; c++) begin
      clk_step();
      if (wrap === 1'b1) wraps++;
      e = exp_obs();
      total++;
      if ({value, wrap, an, seg} !== e) begin
        bad++;
        $display("FAIL up_wrap cyc=%0d got v=%h w=%b an=%b seg=%b want v=%h w=%b an=%b seg=%b",
                 c, value, wrap, an, seg, e[17:10], e[9], e[8:7], e[6:0]);
      end
    end
    total++;
    if (wraps != 1 || value !== 8'h01) begin
      bad++;
      $display("FAIL up_wrap_pulse got wraps=%0d v=%h want wraps=1 v=01", wraps, value);
    end
    $display("test_up_wrap: wraps=%0d value=%h", wraps, value);
  endtask

  task automatic test_down_wrap();
    logic [4*D+D+7:0] e;
    int wraps;
    wraps = 0;
    en = 1'b1; up = 1'b0; load = 1'b1; load_val = 8'h00;
    clk_step();
    load = 1'b0;
    for (int c = 0; c < 8; c++) begin
      clk_step();
      if (wrap === 1'b1) wraps++;
      e = exp_obs();
      total++;
      if ({value, wrap, an, seg} !== e) begin
        bad++;
        $display("FAIL down_wrap cyc=%0d got v=%h w=%b an=%b seg=%b want v=%h w=%b an=%b seg=%b",
                 c, value, wrap, an, seg, e[17:10], e[9], e[8:7], e[6:0]);
      end
    end
    total++;
    if (wraps != 1 || value !== 8'h98) begin
      bad++;
      $display("FAIL down_wrap_pulse got wraps=%0d v=%h want wraps=1 v=98", wraps, value);
    end
    $display("test_down_wrap: wraps=%0d value=%h", wraps, value);
  endtask

  task automatic test_load_collision();
    logic [4*D+D+7:0] e;
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'h20;
    clk_step();
    load = 1'b0;
    for (int c = 0; c < 3; c++) clk_step();
    // prescaler now sits on its last count, so this edge is also a tick
    load = 1'b1; load_val = 8'h5F;
    clk_step();
    load = 1'b0;
    total++;
    if (value !== 8'h59 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL load_tick got v=%h w=%b want v=59 w=0", value, wrap);
    end
    for (int c = 0; c < 4; c++) begin
      clk_step();
      e = exp_obs();
      total++;
      if ({value, wrap, an, seg} !== e) begin
        bad++;
        $display("FAIL load_restart cyc=%0d got v=%h w=%b an=%b seg=%b want v=%h w=%b an=%b seg=%b",
                 c, value, wrap, an, seg, e[17:10], e[9], e[8:7], e[6:0]);
      end
    end
    total++;
    if (value !== 8'h60) begin
      bad++;
      $display("FAIL load_restart_final got=%h want=60", value);
    end
    $display("test_load_collision: value=%h", value);
  endtask

  task automatic test_freeze();
    logic [4*D+D+7:0] e;
    logic [D-1:0]     prev_an;
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'h42;
    clk_step();
    load = 1'b0;
    clk_step();
    clk_step();
    en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      prev_an = an;
      clk_step();
      e = exp_obs();
      total++;
      if ({value, wrap, an, seg} !== e) begin
        bad++;
        $display("FAIL freeze cyc=%0d got v=%h w=%b an=%b seg=%b want v=%h w=%b an=%b seg=%b",
                 c, value, wrap, an, seg, e[17:10], e[9], e[8:7], e[6:0]);
      end
      if (an !== prev_an) begin
        total++;
        if (!(an === 2'b10 || an === 2'b01)) begin
          bad++;
          $display("FAIL freeze_an cyc=%0d got=%b want=10 or 01", c, an);
        end
      end
    end
    total++;
    if (value !== 8'h42) begin
      bad++;
      $display("FAIL freeze_hold got=%h want=42", value);
    end
    en = 1'b1;
    clk_step();
    clk_step();
    total++;
    if (value !== 8'h43) begin
      bad++;
      $display("FAIL freeze_resume got=%h want=43", value);
    end
    $display("test_freeze: value=%h", value);
  endtask

  task automatic test_reset_mid();
    logic [4*D+D+7:0] e;
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'h37;
    clk_step();
    load = 1'b0;
    clk_step();
    clk_step();
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    total++;
    if ({value, wrap, an, seg} !== {8'h00, 1'b0, 2'b10, 7'b0000001}) begin
      bad++;
      $display("FAIL reset_mid got v=%h w=%b an=%b seg=%b want v=00 w=0 an=10 seg=0000001",
               value, wrap, an, seg);
    end
    for (int c = 0; c < 4; c++) begin
      clk_step();
      e = exp_obs();
      total++;
      if ({value, wrap, an, seg} !== e) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got v=%h w=%b an=%b seg=%b want v=%h w=%b an=%b seg=%b",
                 c, value, wrap, an, seg, e[17:10], e[9], e[8:7], e[6:0]);
      end
    end
    total++;
    if (value !== 8'h01) begin
      bad++;
      $display("FAIL reset_first_tick got=%h want=01", value);
    end
    $display("test_reset_mid: value=%h", value);
  endtask

  task automatic test_clamp();
    logic [4*D-1:0] ins [3];
    logic [4*D-1:0] outs [3];
    ins[0] = 8'hAF; outs[0] = 8'h99;
    ins[1] = 8'h0C; outs[1] = 8'h09;
    ins[2] = 8'hF3; outs[2] = 8'h93;
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      load = 1'b1; load_val = ins[k];
      clk_step();
      load = 1'b0;
      total++;
      if (value !== outs[k] || wrap !== 1'b0) begin
        bad++;
        $display("FAIL clamp in=%h got v=%h w=%b want v=%h w=0", ins[k], value, wrap, outs[k]);
      end
      $display("test_clamp: load %h -> %h", ins[k], value);
    end
  endtask

  task automatic test_random();
    logic [4*D+D+7:0] e;
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 49) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 11) == 0);
      load_val = 8'($urandom);
      clk_step();
      e = exp_obs();
      total++;
      if ({value, wrap, an, seg} !== e) begin
        bad++;
        $display("FAIL random cyc=%0d got v=%h w=%b an=%b seg=%b want v=%h w=%b an=%b seg=%b",
                 c, value, wrap, an, seg, e[17:10], e[9], e[8:7], e[6:0]);
      end
    end
    rst = 1'b0; load = 1'b0;
    $display("test_random: 400 cycles, final value=%h", value);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    test_reset();
    test_count_up();
    test_up_wrap();
    test_down_wrap();
    test_load_collision();
    test_freeze();
    test_reset_mid();
    test_clamp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
